// File: rtl/sdram_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_scheduler_pkg
// Purpose  : Shared SDRAM command encodings, default timing and scheduler
//            state encodings for the SDRAM bus scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package sdram_scheduler_pkg;

  // SDRAM commands as {ras_n, cas_n, we_n}
  localparam logic [2:0] c_CMD_NOP   = 3'b111;
  localparam logic [2:0] c_CMD_ACT   = 3'b011;
  localparam logic [2:0] c_CMD_READ  = 3'b101;
  localparam logic [2:0] c_CMD_WRITE = 3'b100;
  localparam logic [2:0] c_CMD_PRE   = 3'b010;
  localparam logic [2:0] c_CMD_AR    = 3'b001;

  // Default SDRAM timing in clk cycles
  localparam int c_T_RP_DEF  = 2;
  localparam int c_T_RFC_DEF = 7;

  // A10 high on PRE selects all banks
  localparam logic [11:0] c_ADDR_ALL_BANKS = 12'h400;

  // Scheduler states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_RELEASE = 3'd2,
    S_REF_PRE = 3'd3,
    S_REF_AR  = 3'd4
  } sched_state_t;

  // Which engine a grant or the round-robin pointer refers to
  typedef enum logic {
    SIDE_RD = 1'b0,
    SIDE_WR = 1'b1
  } side_t;

  // Load value for the 8-bit wait counter
  function automatic logic [7:0] wait_load(input int cycles);
    return 8'(cycles);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_scheduler_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_scheduler_refresh_timer
// Purpose  : Refresh interval counter and saturating count of owed refresh
//            credits. A credit is added each time the interval expires and
//            removed each time the scheduler issues an auto-refresh.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_scheduler_refresh_timer #(
  parameter int REFRESH_INTERVAL = 390,
  parameter int MAX_PENDING      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       consume,
  output logic [3:0] pending
);

  localparam int c_TW = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [c_TW-1:0] c_RELOAD = c_TW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0] c_MAX = 4'(MAX_PENDING);

  logic [c_TW-1:0] r_count;
  logic [3:0]      r_pending;
  logic            w_wrap;
  logic            w_take;

  assign w_wrap  = run && (r_count == '0);
  // A consume with nothing owed is ignored so the credit count cannot wrap
  assign w_take  = consume && (r_pending != 4'd0);
  assign pending = r_pending;

  // Interval counter: counts down while running and reloads on expiry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= c_RELOAD;
    end else if (run) begin
      r_count <= w_wrap ? c_RELOAD : (r_count - c_TW'(1));
    end
  end

  // Credit count: add on expiry (saturating), remove on AR, both cancel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 4'd0;
    end else begin
      case ({w_wrap, w_take})
        2'b10:   if (r_pending < c_MAX) r_pending <= r_pending + 4'd1;
        2'b01:   r_pending <= r_pending - 4'd1;
        default: r_pending <= r_pending;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sdram_scheduler
// Purpose  : Owns the SDRAM command/address bus. Grants it round-robin to the
//            read and write engines, pre-empts them when refresh is overdue,
//            and issues precharge-all / auto-refresh itself.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_scheduler
  import sdram_scheduler_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 390,
  parameter int MAX_PENDING      = 8,
  parameter int T_RP             = c_T_RP_DEF,
  parameter int T_RFC            = c_T_RFC_DEF,
  parameter int GUARD            = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        rd_req,
  input  logic        wr_req,
  output logic        rd_en,
  input  logic        rd_ready,
  output logic        rd_auto_refresh,
  input  logic [2:0]  rd_command,
  input  logic [11:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        wr_en,
  input  logic        wr_ready,
  output logic        wr_auto_refresh,
  input  logic [2:0]  wr_command,
  input  logic [11:0] wr_addr,
  input  logic [1:0]  wr_bank,
  output logic [2:0]  command,
  output logic [11:0] addr,
  output logic [1:0]  bank,
  output logic        busy_rd,
  output logic        busy_wr,
  output logic        refreshing
);

  sched_state_t r_state;
  side_t        r_owner;
  side_t        r_rr_ptr;
  logic         r_rd_en;
  logic         r_wr_en;
  logic         r_rd_ar;
  logic         r_wr_ar;
  logic         r_busy_rd;
  logic         r_busy_wr;
  logic         r_refreshing;
  logic [2:0]   r_ref_cmd;
  logic [11:0]  r_ref_addr;
  logic [7:0]   r_wait;

  logic [3:0]   w_pending;
  logic         w_pending_max;
  logic         w_consume;
  logic         w_req_owner;
  logic         w_ready_owner;
  side_t        w_grant_side;

  // Credit is taken in the cycle the AR is on the bus, so the loop decision
  // at the end of the tRFC gap already sees the decremented count.
  assign w_consume     = (r_state == S_REF_AR) && (r_ref_cmd == c_CMD_AR);
  assign w_pending_max = (w_pending >= 4'(MAX_PENDING));
  assign w_req_owner   = (r_owner == SIDE_RD) ? rd_req   : wr_req;
  assign w_ready_owner = (r_owner == SIDE_RD) ? rd_ready : wr_ready;

  sdram_scheduler_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .MAX_PENDING      (MAX_PENDING)
  ) u_refresh_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (init_done),
    .consume (w_consume),
    .pending (w_pending)
  );

  // Pick the engine to grant from IDLE; contention follows the pointer
  always_comb begin
    w_grant_side = SIDE_RD;
    if (rd_req && wr_req) begin
      w_grant_side = r_rr_ptr;
    end else if (wr_req) begin
      w_grant_side = SIDE_WR;
    end
  end

  // Scheduler FSM with registered engine controls and refresh command
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= SIDE_RD;
      r_rr_ptr     <= SIDE_RD;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rd_ar      <= 1'b0;
      r_wr_ar      <= 1'b0;
      r_busy_rd    <= 1'b0;
      r_busy_wr    <= 1'b0;
      r_refreshing <= 1'b0;
      r_ref_cmd    <= c_CMD_NOP;
      r_ref_addr   <= 12'h000;
      r_wait       <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (init_done) begin
            if (w_pending != 4'd0) begin
              r_state      <= S_REF_PRE;
              r_refreshing <= 1'b1;
              r_ref_cmd    <= c_CMD_PRE;
              r_ref_addr   <= c_ADDR_ALL_BANKS;
              r_wait       <= wait_load(T_RP);
            end else if (rd_req || wr_req) begin
              r_owner   <= w_grant_side;
              r_rd_en   <= (w_grant_side == SIDE_RD);
              r_busy_rd <= (w_grant_side == SIDE_RD);
              r_wr_en   <= (w_grant_side == SIDE_WR);
              r_busy_wr <= (w_grant_side == SIDE_WR);
              r_state   <= S_GRANT;
              if (rd_req && wr_req) begin
                r_rr_ptr <= (r_rr_ptr == SIDE_RD) ? SIDE_WR : SIDE_RD;
              end
            end
          end
        end

        S_GRANT: begin
          if (w_pending_max) begin
            // Overdue refresh: tell the owner to yield and drop its enable
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_rd_ar <= (r_owner == SIDE_RD);
            r_wr_ar <= (r_owner == SIDE_WR);
            r_wait  <= wait_load(GUARD);
            r_state <= S_RELEASE;
          end else if (!w_req_owner) begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_wait  <= wait_load(GUARD);
            r_state <= S_RELEASE;
          end
        end

        S_RELEASE: begin
          // Engine keeps the bus until it reports idle after the guard time
          r_rd_ar <= 1'b0;
          r_wr_ar <= 1'b0;
          if (r_wait != 8'd0) begin
            r_wait <= r_wait - 8'd1;
          end else if (w_ready_owner) begin
            r_busy_rd <= 1'b0;
            r_busy_wr <= 1'b0;
            r_state   <= S_IDLE;
          end
        end

        S_REF_PRE: begin
          r_ref_cmd  <= c_CMD_NOP;
          r_ref_addr <= 12'h000;
          if (r_wait != 8'd0) begin
            r_wait <= r_wait - 8'd1;
          end else begin
            r_ref_cmd <= c_CMD_AR;
            r_wait    <= wait_load(T_RFC);
            r_state   <= S_REF_AR;
          end
        end

        S_REF_AR: begin
          r_ref_cmd <= c_CMD_NOP;
          if (r_wait != 8'd0) begin
            r_wait <= r_wait - 8'd1;
          end else if (w_pending != 4'd0) begin
            // Credits added during the sequence are paid off in this loop
            r_ref_cmd <= c_CMD_AR;
            r_wait    <= wait_load(T_RFC);
          end else begin
            r_refreshing <= 1'b0;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Zero-latency bus mux: bus owner, then refresh sequencer, else NOP
  always_comb begin
    command = c_CMD_NOP;
    addr    = 12'h000;
    bank    = 2'b00;
    if (r_busy_rd) begin
      command = rd_command;
      addr    = rd_addr;
      bank    = rd_bank;
    end else if (r_busy_wr) begin
      command = wr_command;
      addr    = wr_addr;
      bank    = wr_bank;
    end else if (r_refreshing) begin
      command = r_ref_cmd;
      addr    = r_ref_addr;
    end
  end

  assign rd_en           = r_rd_en;
  assign wr_en           = r_wr_en;
  assign rd_auto_refresh = r_rd_ar;
  assign wr_auto_refresh = r_wr_ar;
  assign busy_rd         = r_busy_rd;
  assign busy_wr         = r_busy_wr;
  assign refreshing      = r_refreshing;

endmodule
`default_nettype wire

// File: tb/tb_sdram_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_scheduler
// Purpose  : Directed self-checking bench for sdram_scheduler with a short
//            refresh interval (16) and low pre-emption threshold (2).
//            Cycle k means the k-th rising edge after reset release; outputs
//            are sampled on the falling edge that follows it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_scheduler;

  localparam logic [2:0]  NOP     = 3'b111;
  localparam logic [2:0]  PRE     = 3'b010;
  localparam logic [2:0]  AR      = 3'b001;
  localparam logic [2:0]  RD_CMD  = 3'b101;
  localparam logic [11:0] RD_ADDR = 12'h2A5;
  localparam logic [1:0]  RD_BANK = 2'b10;
  localparam logic [2:0]  WR_CMD  = 3'b100;
  localparam logic [11:0] WR_ADDR = 12'h5C3;
  localparam logic [1:0]  WR_BANK = 2'b01;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        rd_req, wr_req;
  logic        rd_en, wr_en;
  logic        rd_ready, wr_ready;
  logic        rd_auto_refresh, wr_auto_refresh;
  logic [2:0]  rd_command, wr_command, command;
  logic [11:0] rd_addr, wr_addr, addr;
  logic [1:0]  rd_bank, wr_bank, bank;
  logic        busy_rd, busy_wr, refreshing;
  logic [6:0]  ctrl;

  int n_cmp;
  int n_bad;

  // {rd_en, wr_en, rd_ar, wr_ar, busy_rd, busy_wr, refreshing}
  assign ctrl = {rd_en, wr_en, rd_auto_refresh, wr_auto_refresh, busy_rd, busy_wr, refreshing};

  always #5 clk = ~clk;

  sdram_scheduler #(
    .REFRESH_INTERVAL (16),
    .MAX_PENDING      (2),
    .T_RP             (2),
    .T_RFC            (7),
    .GUARD            (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .init_done       (init_done),
    .rd_req          (rd_req),
    .wr_req          (wr_req),
    .rd_en           (rd_en),
    .rd_ready        (rd_ready),
    .rd_auto_refresh (rd_auto_refresh),
    .rd_command      (rd_command),
    .rd_addr         (rd_addr),
    .rd_bank         (rd_bank),
    .wr_en           (wr_en),
    .wr_ready        (wr_ready),
    .wr_auto_refresh (wr_auto_refresh),
    .wr_command      (wr_command),
    .wr_addr         (wr_addr),
    .wr_bank         (wr_bank),
    .command         (command),
    .addr            (addr),
    .bank            (bank),
    .busy_rd         (busy_rd),
    .busy_wr         (busy_wr),
    .refreshing      (refreshing)
  );

  task automatic apply_reset();
    rst = 1'b0; init_done = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_ready = 1'b1; wr_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_reset(input logic init);
    @(negedge clk);
    rst = 1'b1;
    init_done = init;
  endtask

  task automatic test_reset();
    apply_reset();
    rd_req = 1'b1; wr_req = 1'b1;
    #1;
    n_cmp++; if (command !== NOP) begin n_bad++; $display("FAIL reset_cmd got %b want %b", command, NOP); end
    n_cmp++; if (addr !== 12'h000) begin n_bad++; $display("FAIL reset_addr got %h want 000", addr); end
    n_cmp++; if (bank !== 2'b00) begin n_bad++; $display("FAIL reset_bank got %b want 00", bank); end
    n_cmp++; if (ctrl !== 7'b0) begin n_bad++; $display("FAIL reset_ctrl got %b want 0000000", ctrl); end
  endtask

  task automatic test_init_gate();
    logic [2:0] e_cmd;
    logic [6:0] e_ctrl;
    apply_reset();
    release_reset(1'b0);
    rd_req = 1'b1; wr_req = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      n_cmp++; if (command !== NOP) begin n_bad++; $display("FAIL gate_cmd c=%0d got %b want %b", c, command, NOP); end
      n_cmp++; if (ctrl !== 7'b0) begin n_bad++; $display("FAIL gate_ctrl c=%0d got %b want 0000000", c, ctrl); end
    end
    // Timer must not have run: first PRE comes a full interval later
    rd_req = 1'b0; wr_req = 1'b0; init_done = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      e_cmd  = (k == 17) ? PRE : NOP;
      e_ctrl = (k == 17) ? 7'b0000001 : 7'b0;
      n_cmp++; if (command !== e_cmd) begin n_bad++; $display("FAIL gate_first_pre k=%0d got %b want %b", k, command, e_cmd); end
      n_cmp++; if (ctrl !== e_ctrl) begin n_bad++; $display("FAIL gate_first_ctrl k=%0d got %b want %b", k, ctrl, e_ctrl); end
    end
  endtask

  task automatic test_refresh_periodic();
    logic [2:0]  e_cmd;
    logic [11:0] e_addr;
    logic [6:0]  e_ctrl;
    apply_reset();
    release_reset(1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      e_cmd = NOP; e_addr = 12'h000; e_ctrl = 7'b0;
      if (k == 17 || k == 33) begin e_cmd = PRE; e_addr = 12'h400; end
      if (k == 20 || k == 36) e_cmd = AR;
      if ((k >= 17 && k <= 27) || k >= 33) e_ctrl = 7'b0000001;
      n_cmp++; if (command !== e_cmd) begin n_bad++; $display("FAIL refresh_cmd k=%0d got %b want %b", k, command, e_cmd); end
      n_cmp++; if (addr !== e_addr) begin n_bad++; $display("FAIL refresh_addr k=%0d got %h want %h", k, addr, e_addr); end
      n_cmp++; if (ctrl !== e_ctrl) begin n_bad++; $display("FAIL refresh_ctrl k=%0d got %b want %b", k, ctrl, e_ctrl); end
    end
  endtask

  task automatic test_short_grant();
    logic [6:0]  e_ctrl;
    logic [16:0] e_bus;
    apply_reset();
    release_reset(1'b1);
    wr_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) wr_req = 1'b0;
      e_ctrl = 7'b0;
      if (k == 1) e_ctrl[5] = 1'b1;
      if (k <= 4) e_ctrl[1] = 1'b1;
      e_bus = (k <= 4) ? {WR_CMD, WR_ADDR, WR_BANK} : {NOP, 12'h000, 2'b00};
      n_cmp++; if (ctrl !== e_ctrl) begin n_bad++; $display("FAIL short_ctrl k=%0d got %b want %b", k, ctrl, e_ctrl); end
      n_cmp++; if ({command, addr, bank} !== e_bus) begin n_bad++; $display("FAIL short_bus k=%0d got %h want %h", k, {command, addr, bank}, e_bus); end
    end
  endtask

  // Read held throughout: credits reach 2 at cycle 32, yield at 33, engine
  // ready seen at 43, PRE at 44, AR at 47. Credits 48 and 64 land in the same
  // cycle as an AR consume, so ARs follow at 55, 63, 71; read re-granted at 80.
  task automatic test_preempt_coincide();
    logic [6:0]  e_ctrl;
    logic [2:0]  e_cmd;
    logic [11:0] e_addr;
    logic [1:0]  e_bank;
    logic        busy;
    apply_reset();
    rd_ready = 1'b0;
    release_reset(1'b1);
    rd_req = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      busy = (k <= 42) || (k == 80);
      e_ctrl = 7'b0;
      e_ctrl[6] = (k <= 32) || (k == 80);
      e_ctrl[4] = (k == 33);
      e_ctrl[2] = busy;
      e_ctrl[0] = (k >= 44 && k <= 78);
      e_cmd = NOP; e_addr = 12'h000; e_bank = 2'b00;
      if (busy) begin
        e_cmd = RD_CMD; e_addr = RD_ADDR; e_bank = RD_BANK;
      end else if (k == 44) begin
        e_cmd = PRE; e_addr = 12'h400;
      end else if (k == 47 || k == 55 || k == 63 || k == 71) begin
        e_cmd = AR;
      end
      n_cmp++; if (ctrl !== e_ctrl) begin n_bad++; $display("FAIL preempt_ctrl k=%0d got %b want %b", k, ctrl, e_ctrl); end
      n_cmp++; if (command !== e_cmd) begin n_bad++; $display("FAIL preempt_cmd k=%0d got %b want %b", k, command, e_cmd); end
      n_cmp++; if ({addr, bank} !== {e_addr, e_bank}) begin n_bad++; $display("FAIL preempt_addr k=%0d got %h want %h", k, {addr, bank}, {e_addr, e_bank}); end
      if (k == 42) rd_ready = 1'b1;
    end
  endtask

  task automatic test_round_robin();
    int   grants[3];
    int   ng;
    int   rd_on, wr_on, rd_off, wr_off;
    logic p_rd, p_wr;
    ng = 0; rd_on = 0; wr_on = 0; rd_off = 0; wr_off = 0; p_rd = 1'b0; p_wr = 1'b0;
    grants = '{-1, -1, -1};
    apply_reset();
    release_reset(1'b1);
    rd_req = 1'b1; wr_req = 1'b1;
    for (int c = 0; c < 1000 && ng < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (busy_rd && busy_wr) begin n_bad++; $display("FAIL rr_overlap c=%0d got 11 want not both", c); end
      if (busy_rd) begin
        n_cmp++; if ({command, addr, bank} !== {RD_CMD, RD_ADDR, RD_BANK}) begin n_bad++; $display("FAIL rr_rd_bus c=%0d got %h want %h", c, {command, addr, bank}, {RD_CMD, RD_ADDR, RD_BANK}); end
        n_cmp++; if ({wr_en, wr_auto_refresh} !== 2'b00) begin n_bad++; $display("FAIL rr_wr_quiet c=%0d got %b want 00", c, {wr_en, wr_auto_refresh}); end
      end
      if (busy_wr) begin
        n_cmp++; if ({command, addr, bank} !== {WR_CMD, WR_ADDR, WR_BANK}) begin n_bad++; $display("FAIL rr_wr_bus c=%0d got %h want %h", c, {command, addr, bank}, {WR_CMD, WR_ADDR, WR_BANK}); end
        n_cmp++; if ({rd_en, rd_auto_refresh} !== 2'b00) begin n_bad++; $display("FAIL rr_rd_quiet c=%0d got %b want 00", c, {rd_en, rd_auto_refresh}); end
      end
      if (busy_rd && !p_rd && ng < 3) begin grants[ng] = 0; ng++; end
      else if (busy_wr && !p_wr && ng < 3) begin grants[ng] = 1; ng++; end
      p_rd = busy_rd; p_wr = busy_wr;
      // Host and engine models: drop request after 20 enabled cycles,
      // re-request once enable falls; engine idle 5 cycles after enable falls
      if (rd_en) begin
        rd_on++; rd_off = 0; rd_ready = 1'b0;
        if (rd_on >= 20) rd_req = 1'b0;
      end else begin
        rd_on = 0; rd_req = 1'b1;
        if (!rd_ready) begin rd_off++; if (rd_off >= 5) rd_ready = 1'b1; end
      end
      if (wr_en) begin
        wr_on++; wr_off = 0; wr_ready = 1'b0;
        if (wr_on >= 20) wr_req = 1'b0;
      end else begin
        wr_on = 0; wr_req = 1'b1;
        if (!wr_ready) begin wr_off++; if (wr_off >= 5) wr_ready = 1'b1; end
      end
    end
    n_cmp++; if (ng != 3) begin n_bad++; $display("FAIL rr_timeout got %0d grants want 3", ng); end
    n_cmp++; if (grants[0] != 0) begin n_bad++; $display("FAIL rr_grant0 got %0d want 0(rd)", grants[0]); end
    n_cmp++; if (grants[1] != 1) begin n_bad++; $display("FAIL rr_grant1 got %0d want 1(wr)", grants[1]); end
    n_cmp++; if (grants[2] != 0) begin n_bad++; $display("FAIL rr_grant2 got %0d want 0(rd)", grants[2]); end
  endtask

  task automatic test_reset_mid_refresh();
    logic [2:0] e_cmd;
    logic [6:0] e_ctrl;
    apply_reset();
    release_reset(1'b1);
    repeat (23) @(negedge clk);
    n_cmp++; if (ctrl !== 7'b0000001) begin n_bad++; $display("FAIL midref_pre got %b want 0000001", ctrl); end
    rst = 1'b0;
    #1;
    n_cmp++; if ({command, addr, bank} !== {NOP, 12'h000, 2'b00}) begin n_bad++; $display("FAIL midref_bus got %h want %h", {command, addr, bank}, {NOP, 12'h000, 2'b00}); end
    n_cmp++; if (ctrl !== 7'b0) begin n_bad++; $display("FAIL midref_ctrl got %b want 0000000", ctrl); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      e_cmd  = (k == 17) ? PRE : NOP;
      e_ctrl = (k == 17) ? 7'b0000001 : 7'b0;
      n_cmp++; if (command !== e_cmd) begin n_bad++; $display("FAIL midref_after_cmd k=%0d got %b want %b", k, command, e_cmd); end
      n_cmp++; if (ctrl !== e_ctrl) begin n_bad++; $display("FAIL midref_after_ctrl k=%0d got %b want %b", k, ctrl, e_ctrl); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b0; init_done = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_ready = 1'b1; wr_ready = 1'b1;
    rd_command = RD_CMD; rd_addr = RD_ADDR; rd_bank = RD_BANK;
    wr_command = WR_CMD; wr_addr = WR_ADDR; wr_bank = WR_BANK;
    test_reset();
    test_init_gate();
    test_refresh_periodic();
    test_short_grant();
    test_preempt_coincide();
    test_round_robin();
    test_reset_mid_refresh();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sdram_scheduler.md
Name: sdram_scheduler

Overview:
- Owns the single SDRAM command/address bus and shares it between the read engine (sdram_read), the write engine (sdram_write) and the periodic refresh.
- Grants the bus to one engine at a time using round-robin.
- Forces engines to yield when refresh is due, then issues precharge-all and auto-refresh commands itself.
- Sits between the wb_sdram top level (host requests, init_done) and the two engines.

Parameters:
REFRESH_INTERVAL, 390, clk cycles between refresh credits (7.8 us at 50 MHz)
MAX_PENDING, 8, refresh credits at which refresh is forced and the engines are pre-empted
T_RP, 2, precharge-to-next-command cycles
T_RFC, 7, auto-refresh-to-next-command cycles
GUARD, 2, cycles after en deassertion before engine ready is trusted

Ports:
clk  in  1  SDRAM clock
rst  in  1  reset, asynchronous, active-low
init_done  in  1  SDRAM power-up init complete; scheduler inert until high
rd_req  in  1  host wants reads (level)
wr_req  in  1  host wants writes (level)
rd_en  out  1  enable to read engine
rd_ready  in  1  read engine idle
rd_auto_refresh  out  1  one-cycle yield pulse to read engine
rd_command  in  3  read engine command
rd_addr  in  12  read engine address
rd_bank  in  2  read engine bank
wr_en, wr_ready, wr_auto_refresh, wr_command, wr_addr, wr_bank  same as the rd_* ports, for the write engine
command  out  3  SDRAM {ras_n,cas_n,we_n}
addr  out  12  SDRAM address
bank  out  2  SDRAM bank
busy_rd  out  1  read engine currently owns the bus
busy_wr  out  1  write engine currently owns the bus
refreshing  out  1  scheduler executing a refresh sequence

Behaviour:
Reset (rst low, async):
- command=NOP; addr=0; bank=0.
- rd_en, wr_en, *_auto_refresh, busy_*, refreshing all 0.
- Refresh timer loaded with REFRESH_INTERVAL-1; pending=0; round-robin pointer=read.
- Reset mid-sequence abandons it; SDRAM timing is not preserved, and top-level reset re-runs init.

Refresh timer:
- Runs only while init_done=1. Decrements each cycle.
- At 0: reloads and pending += 1, saturating at MAX_PENDING (timer keeps running).
- pending is 4 bits wide.

Bus mux:
- Combinational (zero latency).
- busy_rd: rd_command/rd_addr/rd_bank drive the bus.
- busy_wr: the wr_* inputs drive the bus.
- REFRESH states: internal registered command/addr/bank drive the bus.
- Otherwise: NOP, addr 0, bank 0.
- Engines never issue AR; the scheduler is the sole AR issuer.

States:
- IDLE:
  - init_done=0: stay.
  - pending>0: go to REF_PRE. Refresh has priority at idle.
  - Else if rd_req and wr_req are both high: grant the round-robin pointer's side, then flip the pointer.
  - Else grant whichever request is high.
  - Grant means en=1 and busy_x=1 in the next cycle; go to GRANT.
- GRANT:
  - Hold en while req_x=1 and pending<MAX_PENDING.
  - If pending reaches MAX_PENDING: pulse x_auto_refresh for 1 cycle and drop en in the same cycle.
  - If req_x falls: drop en.
  - In either case go to RELEASE.
- RELEASE:
  - en=0, bus still muxed from engine x.
  - Wait GUARD cycles, then wait for x_ready=1. Then busy_x=0, go to IDLE.
  - No timeout.
- REF_PRE:
  - refreshing=1. Issue PRE with addr[10]=1 (all banks) for 1 cycle, then NOP for T_RP cycles.
- REF_AR:
  - Issue AR for 1 cycle, then NOP for T_RFC cycles. pending -= 1.
  - If pending is still >0 (decrement already applied), repeat REF_AR; else go to IDLE.
  - A credit added during the sequence is included in this loop.
- Timer increment and sequence decrement in the same cycle: net pending unchanged.

Boundary rules:
- A request that arrives during refresh waits.
- Request deasserted in the same cycle it is granted: en pulses 1 cycle, then the normal RELEASE path.
- The un-granted engine always sees en=0 and auto_refresh=0.
- Never busy_rd and busy_wr simultaneously.

Decomposition:
- Shared sdram_include: command encodings (NOP 111, ACT 011, READ 101, WRITE 100, PRE 010, AR 001), T_RP/T_RFC defaults, scheduler state encodings.
- One natural sub-module: sdram_refresh_timer (interval counter plus saturating pending credit; inputs consume and run, output pending).

Test Plan:
- Reset with init_done=0 for 2000 cycles -> command stays NOP, pending stays 0, no en.
- init_done=1, no requests, REFRESH_INTERVAL=16 -> PRE(addr[10]=1) at cycle 17, AR at +3, NOP gap of 7; repeats every 16 cycles.
- rd_req and wr_req both held, engines ready 5 cycles after en falls, host drops each request after 20 cycles -> grants alternate read, write, read; busy_* never overlap; bus shows the granted engine's command.
- rd_req held continuously, MAX_PENDING=2 -> rd_auto_refresh pulses once exactly when pending hits 2; rd_en falls the same cycle; after rd_ready, two ARs back-to-back, then read re-granted.
- Timer wraps in the same cycle an AR is issued -> pending unchanged and an extra AR follows.
- rst asserted during REF_AR NOP gap -> outputs return to reset values asynchronously; first refresh after release only after REFRESH_INTERVAL.
